// File: rtl/frame_queue_writer.sv
// frame_queue_writer
//   Memory-side consumer of the camera capture queue. Each 17-bit queue word
//   is a marker (bit16 = 1) or a 16-bit pixel. The block decodes frame-start,
//   row-start and frame-end markers. It packs pixels into bursts of up to
//   BURST_LEN beats, addressed into a linear frame buffer, and reports frame
//   completion and geometry errors.
//   Optional feature macro: FRAME_DOUBLE_BUFFER_EN. When it is defined, the
//   block ping-pongs between FRAME_BASE_0 and FRAME_BASE_1 after each clean
//   frame.
// Ports:
//   MemoryClk, nRST      clock, synchronous active-low reset
//   queue_*              FIFO pop interface (read data valid the cycle after pop)
//   mem_cmd_*            burst command (addr in pixel units, len 1..BURST_LEN)
//   mem_wdata*           burst beats, valid/ready
//   frame_done           1-cycle pulse after the last beat of a frame
//   err_flags            [0] stray data, [1] row overflow, [2] geometry mismatch
//   frame_buf_sel        buffer currently being written
module frame_queue_writer #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int BURST_LEN    = 16,
  parameter int ADDR_WIDTH   = 21,
  parameter int FRAME_BASE_0 = 0,
  parameter int FRAME_BASE_1 = 307200
) (
  input  logic                         MemoryClk,
  input  logic                         nRST,
  input  logic                         queue_empty,
  output logic                         queue_rd_en,
  input  logic [16:0]                  queue_data,
  output logic                         mem_cmd_valid,
  input  logic                         mem_cmd_ready,
  output logic [ADDR_WIDTH-1:0]        mem_cmd_addr,
  output logic [$clog2(BURST_LEN):0]   mem_cmd_len,
  output logic [15:0]                  mem_wdata,
  output logic                         mem_wdata_valid,
  input  logic                         mem_wdata_ready,
  output logic                         frame_done,
  output logic [2:0]                   err_flags,
  output logic                         frame_buf_sel
);
  localparam int IDX_W = $clog2(BURST_LEN);
  localparam int LEN_W = IDX_W + 1;
  localparam int COL_W = $clog2(FRAME_WIDTH + 1);
  localparam int ROW_W = $clog2(FRAME_HEIGHT + 1) + 1;

  typedef enum logic [1:0] {FETCH, DECODE, CMD, DATA} state_t;
  state_t state, state_nxt;

  logic             in_frame, row_open, pending_done, buf_sel;
  logic [ROW_W-1:0] row, rows_started;
  logic [COL_W-1:0] col;
  logic [LEN_W-1:0] count, beat_idx;
  logic [15:0]      pix_buf [BURST_LEN];

  logic w_fstart, w_rstart, w_fend, w_pix;
  assign w_fstart = (queue_data == 17'h10000);
  assign w_rstart = (queue_data == 17'h10001);
  assign w_fend   = (queue_data == 17'h1FFFF);
  assign w_pix    = !queue_data[16];

  logic                  pix_ok, pix_store, fill, flush, geom_bad, last_beat, done_set;
  logic [2:0]            fe_err;
  logic [31:0]           base;
  logic [ADDR_WIDTH-1:0] cmd_addr;

  always_comb begin
    rows_started = row_open ? row + 1'b1 : '0;
    geom_bad     = (rows_started != ROW_W'(FRAME_HEIGHT)) || (col != COL_W'(FRAME_WIDTH));
    fe_err       = err_flags | {geom_bad, 2'b00};
    pix_ok       = in_frame && row_open && (col != COL_W'(FRAME_WIDTH));
    pix_store    = (state == DECODE) && w_pix && pix_ok;
    fill         = pix_store && (count == LEN_W'(BURST_LEN - 1));
    // A row start or frame end pushes out whatever partial burst is buffered.
    flush        = (state == DECODE) && in_frame && (w_rstart || w_fend) && (count != '0);
    last_beat    = (state == DATA) && mem_wdata_valid && mem_wdata_ready &&
                   (beat_idx == mem_cmd_len - 1'b1);
    done_set     = ((state == DECODE) && w_fend && in_frame && (count == '0)) ||
                   (last_beat && pending_done);
    base         = buf_sel ? 32'(FRAME_BASE_1) : 32'(FRAME_BASE_0);
    // col - count is the first column of the buffered burst, both when the
    // burst fills (pre-increment values) and when it is flushed.
    cmd_addr     = ADDR_WIDTH'(base + 32'(row) * 32'(FRAME_WIDTH) + 32'(col) - 32'(count));
  end

  always_ff @(posedge MemoryClk)
    if (!nRST) state <= FETCH;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (queue_rd_en) state_nxt = DECODE;
      DECODE:  state_nxt = (fill || flush) ? CMD : FETCH;
      CMD:     if (mem_cmd_ready) state_nxt = DATA;
      DATA:    if (last_beat) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // Pops only from FETCH, so at most one word every two cycles, never in CMD/DATA.
  assign queue_rd_en = nRST && (state == FETCH) && !queue_empty;

  always_ff @(posedge MemoryClk) begin
    if (!nRST) begin
      in_frame        <= 1'b0;
      row_open        <= 1'b0;
      pending_done    <= 1'b0;
      row             <= '0;
      col             <= '0;
      count           <= '0;
      beat_idx        <= '0;
      mem_cmd_valid   <= 1'b0;
      mem_cmd_addr    <= '0;
      mem_cmd_len     <= '0;
      mem_wdata       <= '0;
      mem_wdata_valid <= 1'b0;
      frame_done      <= 1'b0;
      err_flags       <= '0;
    end else begin
      frame_done <= done_set;
      if (fill || flush) begin
        mem_cmd_valid <= 1'b1;
        mem_cmd_addr  <= cmd_addr;
        mem_cmd_len   <= fill ? LEN_W'(BURST_LEN) : count;
      end
      case (state)
        DECODE: begin
          if (w_fstart) begin
            // Restart without a frame end: partial data is discarded and flagged.
            err_flags    <= in_frame ? 3'b100 : 3'b000;
            in_frame     <= 1'b1;
            row_open     <= 1'b0;
            row          <= '0;
            col          <= '0;
            count        <= '0;
            pending_done <= 1'b0;
          end else if (w_rstart && in_frame) begin
            if (row_open && (col != COL_W'(FRAME_WIDTH))) err_flags[2] <= 1'b1;
            if (row_open) row <= row + 1'b1;
            row_open <= 1'b1;
            col      <= '0;
          end else if (w_fend) begin
            if (!in_frame) begin
              err_flags[0] <= 1'b1;
            end else begin
              err_flags    <= fe_err;
              in_frame     <= 1'b0;
              pending_done <= (count != '0);
            end
          end else if (w_pix) begin
            if (!in_frame || !row_open)           err_flags[0] <= 1'b1;
            else if (col == COL_W'(FRAME_WIDTH))  err_flags[1] <= 1'b1;
            else begin
              col   <= col + 1'b1;
              count <= count + 1'b1;
            end
          end
        end
        CMD: if (mem_cmd_ready) begin
          mem_cmd_valid <= 1'b0;
          beat_idx      <= '0;
        end
        DATA: begin
          // First DATA cycle only loads beat 0, so beats start two cycles
          // after the command handshake.
          if (!mem_wdata_valid) begin
            mem_wdata_valid <= 1'b1;
            mem_wdata       <= pix_buf[beat_idx[IDX_W-1:0]];
          end else if (mem_wdata_ready) begin
            if (last_beat) begin
              mem_wdata_valid <= 1'b0;
              count           <= '0;
              pending_done    <= 1'b0;
            end else begin
              beat_idx  <= beat_idx + 1'b1;
              mem_wdata <= pix_buf[IDX_W'(beat_idx + 1'b1)];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge MemoryClk)
    if (pix_store) pix_buf[count[IDX_W-1:0]] <= queue_data[15:0];

`ifdef FRAME_DOUBLE_BUFFER_EN
  logic [2:0] done_err;
  assign done_err = (state == DECODE) ? fe_err : err_flags;
  // Only a clean frame flips buffers; an erroneous one is overwritten in place.
  always_ff @(posedge MemoryClk)
    if (!nRST)                               buf_sel <= 1'b0;
    else if (done_set && (done_err == 3'b000)) buf_sel <= !buf_sel;
`else
  assign buf_sel = 1'b0;
`endif

  assign frame_buf_sel = buf_sel;

endmodule
